// File: rtl/adc_axi_reg_read.sv
// AXI-Lite read-only register port: IDLE -> FETCH -> RESP per read.
// ADC_AXI_RD_SLVERR_EN: unmapped reads answer SLVERR instead of OKAY.
module adc_axi_reg_read #(
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 8
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [ADDR_W-1:0]        ARADDR,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [31:0]              RDATA,
  output logic [1:0]               RRESP,
  output logic                     RVALID,
  input  logic                     RREADY,
  input  logic [NUM_REGS*32-1:0]   reg_rdata,
  output logic [NUM_REGS-1:0]      reg_rd_stb
);

  localparam int IW = ADDR_W - 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

`ifdef ADC_AXI_RD_SLVERR_EN
  localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
  localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

  logic [1:0]          state_q, state_d;
  logic                arready_q, arready_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [NUM_REGS-1:0] stb_q, stb_d;
  logic                mapped;
  logic [31:0]         sel_word;
  logic                unused_addr_lsb;

  // byte lanes inside a word carry no meaning for a word-wide register
  assign unused_addr_lsb = ^ARADDR[1:0];

  // decode whether the latched word index names a real register
  always_comb begin
    mapped = (32'(idx_q) < 32'(NUM_REGS));
  end

  // select the addressed register word from the flat bus
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(idx_q) == 32'(i)) sel_word = reg_rdata[32*i +: 32];
    end
  end

  // read FSM next-state, data capture and completion strobe
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    stb_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (ARVALID && arready_q) begin
          idx_d   = ARADDR[ADDR_W-1:2];
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_RESP;
        if (mapped) begin
          rdata_d = sel_word;
          rresp_d = 2'b00;
        end else begin
          rdata_d = '0;
          rresp_d = UNMAP_RESP;
        end
      end
      S_RESP: begin
        if (RREADY) begin
          state_d = S_IDLE;
          for (int i = 0; i < NUM_REGS; i++) begin
            stb_d[i] = mapped && (32'(idx_q) == 32'(i));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    arready_d = (state_d == S_IDLE);
  end

  // state and output registers; ARREADY stays low until the first edge out of reset
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= S_IDLE;
      arready_q <= 1'b0;
      idx_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      stb_q     <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      idx_q     <= idx_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      stb_q     <= stb_d;
    end
  end

  assign ARREADY    = arready_q;
  assign RVALID     = (state_q == S_RESP);
  assign RDATA      = rdata_q;
  assign RRESP      = rresp_q;
  assign reg_rd_stb = stb_q;

endmodule

// File: tb/tb_adc_axi_reg_read.sv
// Directed bench for adc_axi_reg_read with a scoreboard of expected responses.
// Honors ADC_AXI_RD_SLVERR_EN for the unmapped-read response code.
module tb_adc_axi_reg_read;

  localparam int ADDR_W   = 8;
  localparam int NUM_REGS = 8;

`ifdef ADC_AXI_RD_SLVERR_EN
  localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
  localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic [7:0]  stb;
  } exp_t;

  logic                   ACLK;
  logic                   ARESETN;
  logic [ADDR_W-1:0]      ARADDR;
  logic                   ARVALID;
  logic                   ARREADY;
  logic [31:0]            RDATA;
  logic [1:0]             RRESP;
  logic                   RVALID;
  logic                   RREADY;
  logic [NUM_REGS*32-1:0] reg_rdata;
  logic [NUM_REGS-1:0]    reg_rd_stb;

  logic [31:0] regs_m [NUM_REGS];
  exp_t        sb [$];
  int          vectors;
  int          errors;
  int          cyc;

  adc_axi_reg_read #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_rdata(reg_rdata), .reg_rd_stb(reg_rd_stb)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) cyc <= cyc + 1;

  always_comb begin
    reg_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_rdata[32*i +: 32] = regs_m[i];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [ADDR_W-1:0] a);
    exp_t e;
    int   idx;
    idx = int'(a[ADDR_W-1:2]);
    if (idx < NUM_REGS) begin
      e.data = regs_m[idx];
      e.resp = 2'b00;
      e.stb  = 8'(1 << idx);
    end else begin
      e.data = 32'h0;
      e.resp = UNMAP_RESP;
      e.stb  = 8'h00;
    end
    return e;
  endfunction

  task automatic wait_arready();
    int n;
    n = 0;
    while (ARREADY !== 1'b1 && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    chk("arready_wait", 64'(n < 20), 64'(1));
  endtask

  task automatic read_txn(input logic [ADDR_W-1:0] a, input int hold, input bit chg);
    exp_t e;
    exp_t g;
    e = model(a);
    sb.push_back(e);
    ARADDR  = a;
    ARVALID = 1'b1;
    RREADY  = 1'b0;
    wait_arready();
    @(negedge ACLK);
    ARVALID = 1'b0;
    chk("fetch_rvalid", 64'(RVALID), 64'(0));
    chk("fetch_arready", 64'(ARREADY), 64'(0));
    RREADY = (hold == 0);
    @(negedge ACLK);
    chk("resp_rvalid", 64'(RVALID), 64'(1));
    g = sb.pop_front();
    chk("resp_rdata", 64'(RDATA), 64'(g.data));
    chk("resp_rresp", 64'(RRESP), 64'(g.resp));
    for (int i = 0; i < hold; i++) begin
      if (chg && i == 0) regs_m[2] = 32'h12345678;
      chk("hold_arready", 64'(ARREADY), 64'(0));
      chk("hold_rvalid", 64'(RVALID), 64'(1));
      chk("hold_rdata", 64'(RDATA), 64'(g.data));
      chk("hold_stb", 64'(reg_rd_stb), 64'(0));
      @(negedge ACLK);
    end
    chk("pre_hs_rdata", 64'(RDATA), 64'(g.data));
    RREADY = 1'b1;
    @(negedge ACLK);
    chk("post_hs_rvalid", 64'(RVALID), 64'(0));
    chk("post_hs_arready", 64'(ARREADY), 64'(1));
    chk("stb_pulse", 64'(reg_rd_stb), 64'(g.stb));
    @(negedge ACLK);
    chk("stb_clear", 64'(reg_rd_stb), 64'(0));
  endtask

  initial begin
    exp_t g;
    int   t0;
    int   t1;
    vectors = 0;
    errors  = 0;
    cyc     = 0;
    for (int i = 0; i < NUM_REGS; i++) regs_m[i] = 32'hA000_0000 + 32'(i);
    regs_m[2] = 32'hDEADBEEF;
    ARESETN = 1'b0;
    ARADDR  = '0;
    ARVALID = 1'b1;
    RREADY  = 1'b1;

    repeat (3) @(negedge ACLK);
    chk("rst_arready", 64'(ARREADY), 64'(0));
    chk("rst_rvalid", 64'(RVALID), 64'(0));
    chk("rst_rdata", 64'(RDATA), 64'(0));
    chk("rst_rresp", 64'(RRESP), 64'(0));
    chk("rst_stb", 64'(reg_rd_stb), 64'(0));
    ARVALID = 1'b0;
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("rel_arready", 64'(ARREADY), 64'(1));

    read_txn(8'h08, 0, 1'b0);
    read_txn(8'h0B, 0, 1'b0);
    read_txn(8'h08, 5, 1'b1);
    read_txn(8'h40, 0, 1'b0);
    read_txn(8'h1C, 2, 1'b0);

    sb.push_back(model(8'h08));
    ARADDR  = 8'h08;
    ARVALID = 1'b1;
    RREADY  = 1'b0;
    wait_arready();
    @(negedge ACLK);
    ARVALID = 1'b0;
    @(negedge ACLK);
    chk("rst_mid_rvalid_pre", 64'(RVALID), 64'(1));
    ARESETN = 1'b0;
    #1;
    chk("rst_mid_rvalid", 64'(RVALID), 64'(0));
    chk("rst_mid_arready", 64'(ARREADY), 64'(0));
    chk("rst_mid_rdata", 64'(RDATA), 64'(0));
    g = sb.pop_front();
    RREADY = 1'b1;
    repeat (2) @(negedge ACLK);
    chk("rst_mid_stb", 64'(reg_rd_stb), 64'(0));
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("rst_mid_rel_arready", 64'(ARREADY), 64'(1));
    chk("rst_mid_rel_stb", 64'(reg_rd_stb), 64'(0));
    read_txn(8'h00, 0, 1'b0);

    sb.push_back(model(8'h00));
    sb.push_back(model(8'h04));
    ARADDR  = 8'h00;
    ARVALID = 1'b1;
    RREADY  = 1'b1;
    wait_arready();
    t0 = cyc;
    @(negedge ACLK);
    ARADDR = 8'h04;
    chk("b2b_fetch_arready", 64'(ARREADY), 64'(0));
    @(negedge ACLK);
    chk("b2b_rvalid0", 64'(RVALID), 64'(1));
    g = sb.pop_front();
    chk("b2b_rdata0", 64'(RDATA), 64'(g.data));
    chk("b2b_arready_resp", 64'(ARREADY), 64'(0));
    @(negedge ACLK);
    chk("b2b_arready_idle", 64'(ARREADY), 64'(1));
    chk("b2b_stb0", 64'(reg_rd_stb), 64'(g.stb));
    t1 = cyc;
    chk("b2b_period", 64'(t1 - t0), 64'(3));
    @(negedge ACLK);
    ARVALID = 1'b0;
    chk("b2b_fetch1_rvalid", 64'(RVALID), 64'(0));
    @(negedge ACLK);
    chk("b2b_rvalid1", 64'(RVALID), 64'(1));
    g = sb.pop_front();
    chk("b2b_rdata1", 64'(RDATA), 64'(g.data));
    @(negedge ACLK);
    chk("b2b_stb1", 64'(reg_rd_stb), 64'(g.stb));
    @(negedge ACLK);
    chk("b2b_stb_clear", 64'(reg_rd_stb), 64'(0));
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
